// File: rtl/rgb_pwm_engine.sv
// rgb_pwm_engine: multi-channel PWM generator for the board RGB LEDs.
// Duties are double-buffered (pending -> active at period boundaries) and an
// optional breathing mode scales every channel by a ramping brightness level.
module rgb_pwm_engine #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     load,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start,
  output logic                     fade_dir
);

  // Period is 2^DUTY_W-1 cycles, so the counter's last value is all-ones minus one.
  localparam logic [DUTY_W-1:0] LVL_MAX  = '1;
  localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};
  localparam int unsigned       DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [DUTY_W-1:0]        cnt;
  logic [DUTY_W-1:0]        lvl, lvl_nxt;
  logic [DIV_W-1:0]         div, div_nxt;
  logic [NUM_CH*DUTY_W-1:0] pending;
  logic [NUM_CH*DUTY_W-1:0] active;
  logic [DUTY_W-1:0]        eff [NUM_CH];
  logic                     boundary;

  // Brightness scaling: (d * (l+1)) >> DUTY_W, so l = max passes d through and l = 0 gives 0.
  function automatic logic [DUTY_W-1:0] scale(input logic [DUTY_W-1:0] d,
                                              input logic [DUTY_W-1:0] l);
    logic [2*DUTY_W:0] prod;
    prod = (2*DUTY_W+1)'(d) * ((2*DUTY_W+1)'(l) + (2*DUTY_W+1)'(1));
    return DUTY_W'(prod >> DUTY_W);
  endfunction

  assign boundary = en && (cnt == CNT_LAST);
  assign fade_dir = (state == ST_UP);

  // Period counter: runs 0..P-1 while enabled, parked at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DUTY_W'(1);
    end
  end

  // Duty double buffer: load fills pending, boundary promotes pending to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (load) begin
        pending <= duty_in;
      end
      if (boundary) begin
        active <= pending;
      end
    end
  end

  // Breathing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STATIC;
      lvl   <= LVL_MAX;
      div   <= '0;
    end else begin
      state <= state_nxt;
      lvl   <= lvl_nxt;
      div   <= div_nxt;
    end
  end

  // Breathing next-state: only acts on boundaries; mode drop outranks stepping.
  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    div_nxt   = div;
    if (boundary) begin
      unique case (state)
        ST_STATIC: begin
          if (mode) begin
            state_nxt = ST_UP;
            lvl_nxt   = '0;
            div_nxt   = '0;
          end
        end
        ST_UP: begin
          if (!mode) begin
            state_nxt = ST_STATIC;
            lvl_nxt   = LVL_MAX;
            div_nxt   = '0;
          end else if (div == DIV_LAST) begin
            div_nxt = '0;
            lvl_nxt = lvl + DUTY_W'(1);
            if (lvl_nxt == LVL_MAX) begin
              state_nxt = ST_DOWN;
            end
          end else begin
            div_nxt = div + DIV_W'(1);
          end
        end
        ST_DOWN: begin
          if (!mode) begin
            state_nxt = ST_STATIC;
            lvl_nxt   = LVL_MAX;
            div_nxt   = '0;
          end else if (div == DIV_LAST) begin
            div_nxt = '0;
            lvl_nxt = lvl - DUTY_W'(1);
            if (lvl_nxt == '0) begin
              state_nxt = ST_UP;
            end
          end else begin
            div_nxt = div + DIV_W'(1);
          end
        end
        default: begin
          state_nxt = ST_STATIC;
          lvl_nxt   = LVL_MAX;
          div_nxt   = '0;
        end
      endcase
    end
  end

  // Effective duty per channel: raw active duty, or brightness-scaled while breathing.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (state == ST_STATIC) begin
        eff[i] = active[i*DUTY_W +: DUTY_W];
      end else begin
        eff[i] = scale(active[i*DUTY_W +: DUTY_W], lvl);
      end
    end
  end

  // Registered outputs; a full-scale duty never drops low since cnt stops at P-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= en && (cnt < eff[i]);
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_engine.sv
// tb_rgb_pwm_engine: directed bench with a scoreboard of expected per-period
// high times. A second instance (DUTY_W=4, STEP_DIV=1) covers a full breathing cycle.
module tb_rgb_pwm_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic        load;
  logic [23:0] duty_in;
  logic [11:0] duty_b;
  logic [2:0]  pwm_out;
  logic [2:0]  pwm_b;
  logic        period_start;
  logic        ps_b;
  logic        fade_dir;
  logic        fd_b;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];

  always #5 clk = ~clk;

  rgb_pwm_engine #(.NUM_CH(3), .DUTY_W(8), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_start(period_start), .fade_dir(fade_dir)
  );

  rgb_pwm_engine #(.NUM_CH(3), .DUTY_W(4), .STEP_DIV(1)) dutb (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .duty_in(duty_b),
    .pwm_out(pwm_b), .period_start(ps_b), .fade_dir(fd_b)
  );

  function automatic int breath(input int d, input int l);
    return (d * (l + 1)) >> 8;
  endfunction

  task automatic expect_v(input int v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input int obs);
    int e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic wait_ps(input string tag);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (period_start) return;
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed no period_start expected one within 600 cycles", tag);
  endtask

  task automatic wait_ps_b(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ps_b) return;
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed no period_start expected one within 100 cycles", tag);
  endtask

  // Measure one period of the 8-bit instance starting at a period_start sample;
  // optionally pulse load at cycle ld_at of that period.
  task automatic period(input string tag, input int ld_at, input logic [23:0] ld_val,
                        input int e0, input int e1, input int e2);
    int h0, h1, h2, len;
    expect_v(e0); expect_v(e1); expect_v(e2); expect_v(255);
    h0 = 0; h1 = 0; h2 = 0; len = 0;
    do begin
      if (len == ld_at) begin
        duty_in = ld_val;
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      len++;
      @(negedge clk);
    end while (!period_start && len < 600);
    load = 1'b0;
    check({tag, ".r"}, h0);
    check({tag, ".g"}, h1);
    check({tag, ".b"}, h2);
    check({tag, ".len"}, len);
  endtask

  task automatic period_b(input string tag, input int eh, input int efd);
    int h0, h2, len;
    expect_v(efd);
    check({tag, ".fade"}, int'(fd_b));
    expect_v(eh); expect_v(eh); expect_v(15);
    h0 = 0; h2 = 0; len = 0;
    do begin
      h0 += int'(pwm_b[0]);
      h2 += int'(pwm_b[2]);
      len++;
      @(negedge clk);
    end while (!ps_b && len < 100);
    check({tag, ".r"}, h0);
    check({tag, ".b"}, h2);
    check({tag, ".len"}, len);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    mode    = 1'b0;
    load    = 1'b0;
    duty_in = '0;
    duty_b  = 12'hFFF;
    repeat (3) @(negedge clk);
    expect_v(0); check("rst.pwm", int'(pwm_out));
    expect_v(0); check("rst.ps", int'(period_start));
    expect_v(0); check("rst.fade", int'(fade_dir));
    expect_v(0); check("rst.pwm_b", int'(pwm_b));

    // 1: static duties; first period still runs on the reset (zero) active duty
    rst     = 1'b0;
    duty_in = {8'hFF, 8'h1F, 8'h7F};
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    wait_ps("t1.start");
    period("t1.p1", -1, '0, 0, 0, 0);
    period("t1.p2", -1, '0, 127, 31, 255);
    expect_v(0); check("t1.fade", int'(fade_dir));

    // 2: zero duty for three periods, then full scale
    period("t2.p3", 0, 24'h000000, 127, 31, 255);
    period("t2.p4", -1, '0, 0, 0, 0);
    period("t2.p5", -1, '0, 0, 0, 0);
    period("t2.p6", 0, 24'hFFFFFF, 0, 0, 0);
    period("t2.p7", -1, '0, 255, 255, 255);
    period("t2.p8", -1, '0, 255, 255, 255);

    // 3: mid-period reload only takes effect at the next boundary
    period("t3.p9", 0, {8'h20, 8'h80, 8'h40}, 255, 255, 255);
    period("t3.p10", 100, {8'h20, 8'h80, 8'hC0}, 64, 128, 32);
    period("t3.p11", -1, '0, 192, 128, 32);

    // 4: breathing with STEP_DIV=4, then drop back to static
    mode = 1'b1;
    period("t4.p12", 0, {8'hFF, 8'h80, 8'h40}, 192, 128, 32);
    for (int k = 0; k < 12; k++) begin
      expect_v(1); check($sformatf("t4.fade%0d", k), int'(fade_dir));
      period($sformatf("t4.up%0d", k), -1, '0,
             breath(64, k / 4), breath(128, k / 4), breath(255, k / 4));
    end
    mode = 1'b0;
    period("t4.p25", -1, '0, 1, 2, 3);
    expect_v(0); check("t4.fade_off", int'(fade_dir));
    period("t4.p26", -1, '0, 64, 128, 255);

    // 4b: full breathing cycle on the 4-bit instance, STEP_DIV=1
    wait_ps_b("t4b.sync");
    mode = 1'b1;
    wait_ps_b("t4b.start");
    for (int k = 0; k <= 30; k++) begin
      period_b($sformatf("t4b.k%0d", k),
               (k <= 15) ? k : ((k <= 29) ? 30 - k : 0),
               (k <= 14 || k == 30) ? 1 : 0);
    end
    mode = 1'b0;

    // 5: asynchronous reset while outputs are high
    wait_ps("t5.a");
    wait_ps("t5.b");
    repeat (50) @(negedge clk);
    expect_v(7); check("t5.pre", int'(pwm_out));
    rst = 1'b1;
    #1;
    expect_v(0); check("t5.pwm", int'(pwm_out));
    expect_v(0); check("t5.ps", int'(period_start));
    expect_v(0); check("t5.fade", int'(fade_dir));
    @(negedge clk);
    rst = 1'b0;
    wait_ps("t5.restart");
    period("t5.q1", 0, {3{8'h30}}, 0, 0, 0);
    period("t5.q2", -1, '0, 48, 48, 48);

    // 6: disable mid-period, load while disabled, re-enable
    repeat (20) @(negedge clk);
    expect_v(7); check("t6.pre", int'(pwm_out));
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        duty_in = {3{8'h10}};
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      expect_v(0); check($sformatf("t6.off%0d", i), int'({period_start, pwm_out}));
    end
    load = 1'b0;
    en   = 1'b1;
    @(negedge clk);
    expect_v(1); check("t6.ps", int'(period_start));
    period("t6.r1", -1, '0, 48, 48, 48);
    period("t6.r2", -1, '0, 16, 16, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_engine.md
Name: rgb_pwm_engine

Overview:
Parametrised multi-channel PWM generator for the board RGB LEDs. It takes per-channel duty values, such as those from the switch decode logic, and produces glitch-free PWM waveforms. Duty updates are double-buffered and applied only at period boundaries. An optional breathing mode ramps the brightness of every channel up and down at a programmable rate.

Parameters:
NUM_CH, 3, number of PWM channels (channel 0 = R, 1 = G, 2 = B in the default configuration)
DUTY_W, 8, duty/counter width in bits; PWM period P = 2^DUTY_W - 1 clock cycles
STEP_DIV, 4, number of PWM periods per breathing level step; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; 0 freezes the engine and forces outputs low
mode  input  1  0 = static duty, 1 = breathing
load  input  1  single-cycle strobe; captures duty_in into the pending registers
duty_in  input  NUM_CH*DUTY_W  packed duties, channel i at bits [i*DUTY_W +: DUTY_W]
pwm_out  output  NUM_CH  registered PWM outputs, active high
period_start  output  1  one-cycle pulse on the first output cycle of each period
fade_dir  output  1  1 while breathing level ramps up, 0 otherwise

Behaviour:
- One clock; reset is asynchronous and active-high, using ports clk and rst.
- Reset (immediate, no clock edge needed): cnt=0, pending=0, active=0, lvl=2^DUTY_W-1, div=0, state=STATIC, pwm_out=0, period_start=0, fade_dir=0.
- Period counter cnt counts 0..P-1 and wraps to 0 while en=1. The "boundary" is the clock edge at which cnt wraps from P-1 to 0.
- Effective duty:
  - STATIC: eff[i] = active[i].
  - UP/DOWN: eff[i] = (active[i]*(lvl+1)) >> DUTY_W, using a (2*DUTY_W+1)-bit product. lvl=max gives eff=active; lvl=0 gives eff=0.
- pwm_out[i] <= (cnt < eff[i]), registered, so the outputs lag cnt by one cycle. Duty 0 gives constant low; duty 2^DUTY_W-1 gives constant high with no glitch at the boundary.
- period_start <= (cnt==0) && en, aligned with the pwm_out cycle of cnt==0.
- Double buffering:
  - load=1 sets pending <= duty_in on that edge.
  - At each boundary, active <= pending.
  - A load on the boundary edge itself is applied at the following boundary.
  - Repeated loads within one period: the last one wins.
- Breathing FSM; state and lvl update only at boundaries:
  - STATIC: on mode=1, go to UP with lvl=0 and div=0. lvl stays at max while in STATIC.
  - UP: div increments each boundary. When div reaches STEP_DIV-1, div=0 and lvl++. When lvl reaches max, go to DOWN.
  - DOWN: same stepping, with lvl--. When lvl reaches 0, go to UP.
  - UP/DOWN: on mode=0 at a boundary, go to STATIC with lvl=max and div=0. This check takes priority over stepping.
  - fade_dir = (state==UP).
- en=0: cnt is held at 0, pwm_out=0, period_start=0, and the FSM is frozen; pending still accepts load. When en returns to 1, counting resumes from cnt=0 and period_start pulses on the next cycle.
- Full breathing cycle = 2*(2^DUTY_W-1)*STEP_DIV periods.

Test Plan:
1. Defaults, mode=0, duty R=0x7F, G=0x1F, B=0xFF, load, en=1 -> from the first period_start after a boundary: period 255 cycles; R high 127, G high 31, B high 255 (continuous).
2. Duty 0x00 on all channels -> pwm_out stays 0 for 3 full periods. Then load 0xFF -> constant high from the next period, with no low cycle at the wrap.
3. Active R=0x40; load R=0xC0 at cnt=100 -> the current period finishes with 64 high cycles, and the next period has 192 high cycles.
4. STEP_DIV=1, active all 0xFF, mode=1 -> high time of period k equals k for k=0..255, then decreases 254..0. fade_dir falls when lvl reaches 255. Pattern repeats every 510 periods.
5. Assert rst at cnt=50 while pwm_out=1 -> pwm_out and period_start go 0 within the same cycle. After release, no output until a load followed by a boundary.
6. en=0 mid-period, load 0x10 during en=0, then en=1 -> outputs low while disabled; on re-enable, cnt restarts at 0 and the new duty 0x10 is applied from the first boundary.
